// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined barrel shifter (ASR/LSR/LSL/ROR), one stage per shamt bit
// Define ROUND_EN to make ASR round half-up via a per-stage guard bit.
module barrel_shift_pipe #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [N-1:0]   d_i,
    input  logic [SHW-1:0] shamt_i,
    input  logic [1:0]     mode_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [N-1:0]   q_o
);

    typedef enum logic [1:0] {
        MODE_ASR = 2'b00,
        MODE_LSR = 2'b01,
        MODE_LSL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    logic adv;

    // The whole pipe advances in lockstep; any stall freezes every stage.
    assign adv     = ~valid_o | ready_i;
    assign ready_o = adv;

    for (genvar k = 0; k < SHW; k++) begin : stg
        localparam int AMT  = 1 << k;
        localparam int RAMT = AMT % N;
        localparam int GIDX = (AMT > N) ? N - 1 : AMT - 1;

        logic [N-1:0]   d_in;
        logic [SHW-1:k] s_in;
        logic [1:0]     m_in;
        logic           v_in;
        logic [N-1:0]   d_sh;
        logic [N-1:0]   d_nxt;
        logic [N-1:0]   d_q;
        logic           v_q;
`ifdef ROUND_EN
        logic           g_in;
        logic           g_nxt;
`endif

        if (k == 0) begin : g_src
            assign d_in = d_i;
            assign s_in = shamt_i;
            assign m_in = mode_i;
            assign v_in = valid_i;
`ifdef ROUND_EN
            assign g_in = 1'b0;
`endif
        end else begin : g_src
            assign d_in = stg[k-1].d_q;
            assign s_in = stg[k-1].g_fwd.s_q;
            assign m_in = stg[k-1].g_fwd.m_q;
            assign v_in = stg[k-1].v_q;
`ifdef ROUND_EN
            assign g_in = stg[k-1].g_fwd.g_q;
`endif
        end

        // Shifts of AMT >= N fall out naturally: all sign bits for ASR, zero for LSR/LSL.
        always_comb begin
            d_sh = d_in;
            if (s_in[k]) begin
                case (mode_e'(m_in))
                    MODE_ASR: d_sh = $signed(d_in) >>> AMT;
                    MODE_LSR: d_sh = d_in >> AMT;
                    MODE_LSL: d_sh = d_in << AMT;
                    default:  d_sh = (d_in >> RAMT) | (d_in << (N - RAMT));
                endcase
            end
        end

`ifdef ROUND_EN
        // Guard tracks the most significant bit shifted out so far.
        assign g_nxt = s_in[k] ? d_in[GIDX] : g_in;
`endif

        if (k == SHW - 1) begin : g_out
`ifdef ROUND_EN
            assign d_nxt = d_sh + {{(N-1){1'b0}}, g_nxt & (m_in == MODE_ASR)};
`else
            assign d_nxt = d_sh;
`endif
        end else begin : g_out
            assign d_nxt = d_sh;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                d_q <= '0;
                v_q <= 1'b0;
            end else if (adv) begin
                d_q <= d_nxt;
                v_q <= v_in;
            end
        end

        // Control fields only travel as far as a later stage still needs them.
        if (k < SHW - 1) begin : g_fwd
            logic [SHW-1:k+1] s_q;
            logic [1:0]       m_q;
`ifdef ROUND_EN
            logic             g_q;
`endif

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s_q <= '0;
                    m_q <= 2'b00;
`ifdef ROUND_EN
                    g_q <= 1'b0;
`endif
                end else if (adv) begin
                    s_q <= s_in[SHW-1:k+1];
                    m_q <= m_in;
`ifdef ROUND_EN
                    g_q <= g_nxt;
`endif
                end
            end
        end
    end

    assign valid_o = stg[SHW-1].v_q;
    assign q_o     = stg[SHW-1].d_q;

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - self-checking bench for barrel_shift_pipe
module tb_barrel_shift_pipe;
    localparam int N   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           valid_i;
    logic           ready_o;
    logic [N-1:0]   d_i;
    logic [SHW-1:0] shamt_i;
    logic [1:0]     mode_i;
    logic           valid_o;
    logic           ready_i;
    logic [N-1:0]   q_o;

    barrel_shift_pipe #(.N(N), .SHW(SHW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .d_i     (d_i),
        .shamt_i (shamt_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .q_o     (q_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] exp;
        int           acc_cyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   outs   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int s, input logic [1:0] m);
        logic [N-1:0] r;
        longint       x;
        case (m)
            2'b00: begin
                x = longint'($signed(d));
`ifdef ROUND_EN
                if (s > 0) x = x + (longint'(1) << (s - 1));
`endif
                x = x >>> s;
                r = x[N-1:0];
            end
            2'b01:   r = (s >= N) ? '0 : d >> s;
            2'b10:   r = (s >= N) ? '0 : d << s;
            default: begin
                r = d;
                for (int i = 0; i < s % N; i++) r = {r[0], r[N-1:1]};
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_i && valid_o && ready_i) begin
            outs++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_output: observed %h expected none", q_o);
            end else begin
                e = sb.pop_front();
                check("result", q_o, e.exp);
                if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(SHW));
            end
        end
    end

    task automatic drive(input logic v, input logic [N-1:0] d, input logic [SHW-1:0] s,
                         input logic [1:0] m, input logic [N-1:0] exp, input bit lat,
                         input logic rdy, output bit acc);
        @(posedge clk);
        #1;
        valid_i = v;
        d_i     = d;
        shamt_i = s;
        mode_i  = m;
        ready_i = rdy;
        @(negedge clk);
        acc = v && ready_o;
        if (acc) sb.push_back('{exp, cyc, lat});
    endtask

    task automatic send(input logic [N-1:0] d, input logic [SHW-1:0] s, input logic [1:0] m,
                        input logic [N-1:0] exp, input bit lat);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive(1'b1, d, s, m, exp, lat, 1'b1, acc);
            tries++;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain(input string tag);
        bit acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            drive(1'b0, '0, '0, 2'b00, '0, 0, 1'b1, acc);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    logic [N-1:0]   sd   [8];
    logic [SHW-1:0] ss   [8];
    logic [1:0]     sm   [8];
    logic [N-1:0]   held;
    bit             acc;
    int             idx;
    int             t;
    int             outs0;
    bit             rdy;

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        d_i     = '0;
        shamt_i = '0;
        mode_i  = 2'b00;
        #2;
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_q_o", q_o, 32'h0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        send(32'h8000_0000, 5'd4, 2'b00, 32'hF800_0000, 1);
        send(32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000, 1);
        send(32'h0000_0001, 5'd31, 2'b10, 32'h8000_0000, 1);
        send(32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000, 1);
        send(32'h1234_5678, 5'd0, 2'b11, 32'h1234_5678, 1);
        send(32'h8000_0000, 5'd31, 2'b00, 32'hFFFF_FFFF, 1);
        send(32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1);
`ifdef ROUND_EN
        send(32'h0000_0003, 5'd1, 2'b00, 32'h0000_0002, 1);
        send(32'hFFFF_FFFD, 5'd1, 2'b00, 32'hFFFF_FFFF, 1);
        send(32'h7FFF_FFFF, 5'd1, 2'b00, 32'h4000_0000, 1);
`else
        send(32'h0000_0003, 5'd1, 2'b00, 32'h0000_0001, 1);
        send(32'hFFFF_FFFD, 5'd1, 2'b00, 32'hFFFF_FFFE, 1);
        send(32'h7FFF_FFFF, 5'd1, 2'b00, 32'h3FFF_FFFF, 1);
`endif
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0]   rd;
            logic [SHW-1:0] rs;
            rd = $urandom;
            rs = SHW'($urandom_range(0, 31));
            send(rd, rs, 2'(i % 4), model(rd, int'(rs), 2'(i % 4)), 1);
        end
        drain("drain_directed");

        for (int i = 0; i < 8; i++) begin
            sd[i] = $urandom;
            ss[i] = SHW'($urandom_range(0, 31));
            sm[i] = 2'($urandom_range(0, 3));
        end
        outs0 = outs;
        idx   = 0;
        t     = 0;
        while (idx < 8 && t < 40) begin
            rdy = !(t >= 6 && t < 9);
            drive(1'b1, sd[idx], ss[idx], sm[idx], model(sd[idx], int'(ss[idx]), sm[idx]), 0, rdy, acc);
            if (acc) idx++;
            if (!rdy) begin
                check("stall_ready_o", 32'(ready_o), 32'd0);
                check("stall_valid_o", 32'(valid_o), 32'd1);
                if (t == 6) held = q_o;
                else check("stall_hold", q_o, held);
            end
            t++;
        end
        check("stream_accepted", 32'(idx), 32'd8);
        drain("drain_stream");
        check("stream_outputs", 32'(outs - outs0), 32'd8);

        outs0 = outs;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA5A5_0000 + 32'(i), 5'd3, 2'b01, '0, 0, 1'b1, acc);
            check("pre_reset_valid_o", 32'(valid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        rst_i   = 1'b1;
        #1;
        check("async_reset_valid_o", 32'(valid_o), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, '0, 2'b00, '0, 0, 1'b1, acc);
            check("post_reset_valid_o", 32'(valid_o), 32'd0);
        end
        check("reset_no_outputs", 32'(outs - outs0), 32'd0);
        send(32'hF000_000F, 5'd4, 2'b11, 32'hFF00_0000, 1);
        drain("drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
